// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS sequencer: opcodes (common with the
// pipeline decoder), state encoding, ALU select encodings and the control word.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_NOP   = 6'b100000;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_FETCH  = 4'd1;
    localparam state_t S_DECODE = 4'd2;
    localparam state_t S_MEMADR = 4'd3;
    localparam state_t S_MEMRD  = 4'd4;
    localparam state_t S_MEMWB  = 4'd5;
    localparam state_t S_MEMWR  = 4'd6;
    localparam state_t S_EXEC   = 4'd7;
    localparam state_t S_RWB    = 4'd8;
    localparam state_t S_BEQEX  = 4'd9;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       retire;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Per-state datapath control word; Mealy only on mem_ready in the memory-wait states.
module mc_output_decode
    import mc_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        // NOTE: default every field first so no path through the case infers a latch.
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.iord      = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.retire     = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.retire    = mem_ready_i;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.retire     = 1'b1;
            end
            S_BEQEX: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = 1'b1;
                ctrl_o.retire        = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle sequencer: state register, next-state logic, opcode latch and
// retired-instruction counter; the control word comes from mc_output_decode.
module mc_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        pc_source,
    output logic        retire,
    output logic        illegal,
    output logic [15:0] instret
);

    state_t      state_q, state_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [15:0] instret_q, instret_d;
    logic        nop_retire;
    logic        illegal_op;
    ctrl_t       ctrl;

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        nop_retire = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = opcode;
                if (is_mem_op(opcode)) begin
                    state_d = S_MEMADR;
                end else begin
                    case (opcode)
                        OP_RTYPE: state_d = S_EXEC;
                        OP_BEQ:   state_d = S_BEQEX;
                        OP_NOP: begin
                            state_d    = S_FETCH;
                            nop_retire = 1'b1;
                        end
                        default: begin
                            state_d    = S_FETCH;
                            illegal_op = 1'b1;
                        end
                    endcase
                end
            end
            // Only LW and SW reach MEMADR, so the latched opcode picks the direction.
            S_MEMADR: state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQEX:  state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    mc_output_decode u_output_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign retire    = ctrl.retire | nop_retire;
    assign illegal   = illegal_op;
    assign instret_d = instret_q + {15'd0, retire};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            instret_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            instret_q <= instret_d;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign instret       = instret_q;

endmodule
